// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the fetch/data memory bus arbiter
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant; last_grant state is held by the parent
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic   req_fetch,
  input  logic   req_data,
  input  grant_t last_grant,
  output grant_t grant
);

  // On a tie, serve whoever did not get the bus last time.
  always_comb begin
    grant = GNT_FETCH;
    if (req_fetch && req_data) begin
      grant = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (req_data) begin
      grant = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one Avalon-style memory bus between instruction fetch and data access
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifetch_req,
  input  logic [ADDR_W-1:0]     ifetch_addr,
  output logic                  ifetch_valid,
  output logic [DATA_W-1:0]     ifetch_rdata,
  input  logic                  dmem_req,
  input  logic                  dmem_write,
  input  logic [ADDR_W-1:0]     dmem_addr,
  input  logic [DATA_W/8-1:0]   dmem_byteenable,
  input  logic [DATA_W-1:0]     dmem_wdata,
  output logic                  dmem_done,
  output logic [DATA_W-1:0]     dmem_rdata,
  output logic [ADDR_W-1:0]     bus_address,
  output logic [DATA_W/8-1:0]   bus_byteenable,
  output logic [DATA_W-1:0]     bus_writedata,
  output logic                  bus_read,
  output logic                  bus_write,
  input  logic                  bus_waitrequest,
  input  logic [DATA_W-1:0]     bus_readdata,
  output logic                  stall
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL = (BE_W == 4) ? BE_W'(BE_WORD) : {BE_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q;
  grant_t     grant;
  logic       grant_load;
  logic       complete;

  rr_arb2 u_rr_arb2 (
    .req_fetch  (ifetch_req),
    .req_data   (dmem_req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    complete   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ifetch_req || dmem_req) begin
          grant_load = 1'b1;
          state_d    = (grant == GNT_FETCH) ? FETCH : DATA;
        end
      end
      FETCH, DATA: begin
        if (!bus_waitrequest) begin
          complete = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are captured at grant and held until completion, so the
  // core may change its request inputs without disturbing the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= GNT_DATA;
      bus_address    <= '0;
      bus_byteenable <= '0;
      bus_writedata  <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      ifetch_valid   <= 1'b0;
      ifetch_rdata   <= '0;
      dmem_done      <= 1'b0;
      dmem_rdata     <= '0;
    end else begin
      state_q      <= state_d;
      ifetch_valid <= 1'b0;
      dmem_done    <= 1'b0;
      if (grant_load) begin
        if (grant == GNT_FETCH) begin
          bus_address    <= ifetch_addr & ADDR_MASK;
          bus_byteenable <= BE_ALL;
          bus_writedata  <= '0;
          bus_read       <= 1'b1;
          bus_write      <= 1'b0;
        end else begin
          bus_address    <= dmem_addr & ADDR_MASK;
          bus_byteenable <= dmem_byteenable;
          bus_writedata  <= dmem_wdata;
          bus_read       <= ~dmem_write;
          bus_write      <= dmem_write;
        end
      end
      if (complete) begin
        bus_read  <= 1'b0;
        bus_write <= 1'b0;
        if (state_q == FETCH) begin
          last_grant_q <= GNT_FETCH;
          ifetch_valid <= 1'b1;
          ifetch_rdata <= bus_readdata;
        end else begin
          last_grant_q <= GNT_DATA;
          dmem_done    <= 1'b1;
          if (bus_read) begin
            dmem_rdata <= bus_readdata;
          end
        end
      end
    end
  end

  assign stall = (ifetch_req | dmem_req) & (state_q != RESP);

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the CPU's single external memory bus between instruction fetch and data load/store. It sits between the core and an Avalon-style memory port with `waitrequest`. It turns two level-held requests into one bus transaction at a time, returns read data with a one-cycle done pulse, and drives `stall` to freeze the core's PC and register writes while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, bus and request address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` bits wide

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `ifetch_req`  in  1  fetch request, held until `ifetch_valid`
- `ifetch_addr`  in  ADDR_W  fetch address, stable while `ifetch_req`=1
- `ifetch_valid`  out  1  one-cycle pulse; `ifetch_rdata` valid
- `ifetch_rdata`  out  DATA_W  fetched instruction
- `dmem_req`  in  1  data request, held until `dmem_done`
- `dmem_write`  in  1  1=store, 0=load
- `dmem_addr`  in  ADDR_W  data address
- `dmem_byteenable`  in  DATA_W/8  store/load lane mask
- `dmem_wdata`  in  DATA_W  store data
- `dmem_done`  out  1  one-cycle completion pulse
- `dmem_rdata`  out  DATA_W  load data, valid with `dmem_done`
- `bus_address`, `bus_byteenable`, `bus_writedata`  out  bus transaction fields
- `bus_read`, `bus_write`  out  1  command strobes, mutually exclusive
- `bus_waitrequest`  in  1  slave not ready
- `bus_readdata`  in  DATA_W  valid in the cycle `bus_read`=1 and `bus_waitrequest`=0
- `stall`  out  1  core hold

## Operation
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE → FETCH or DATA when a request is pending, chosen by two-way round-robin.
  - A `last_grant` bit favours the requester not served last.
  - `last_grant` resets to "data", so fetch wins the first tie after reset.
- FETCH drives:
  - `bus_read`=1
  - `bus_address`=`ifetch_addr` with bits [1:0] forced to 0
  - `bus_byteenable`=all ones
- DATA drives:
  - `bus_read`=~`dmem_write` and `bus_write`=`dmem_write`
  - `bus_address`=`dmem_addr` with bits [1:0] forced to 0
  - `bus_byteenable`=`dmem_byteenable` and `bus_writedata`=`dmem_wdata`
- Bus fields are registered on the grant edge and held constant until completion, even if the core's inputs change.
- Completion happens in the first FETCH/DATA cycle with `bus_waitrequest`=0.
  - On a read, `bus_readdata` is captured on that edge.
  - The FSM then moves to RESP and `last_grant` is updated.
- RESP:
  - Strobes are 0.
  - Exactly one of `ifetch_valid`/`dmem_done` is 1, and the matching rdata holds the captured word.
  - Next state is IDLE. Requests are not sampled in RESP.
- `stall` = (`ifetch_req` | `dmem_req`) & ~(RESP).
- Rdata outputs hold their last captured value until the next read completion.

Boundary cases:
- Request dropped mid-transaction: this is a protocol violation. The transaction still completes and pulses done.
- Store with `dmem_byteenable`=0: issued unchanged.
- `bus_waitrequest` held high: the FSM waits indefinitely (no timeout) with strobes held.
- `reset` in any state: next edge gives IDLE, strobes 0, no done pulse, `last_grant`="data", rdata=0.
- Both requests high in IDLE: one is granted; the other stays pending and is granted after RESP.

## Timing
- Reset values: all outputs 0 except `stall`, which is combinational from inputs.
- Request high in IDLE at cycle t → strobe at t+1.
- With `waitrequest`=0 at t+1 → done pulse at t+2 → IDLE at t+3. Minimum 3 cycles per access.
- Each waitrequest cycle adds one cycle.
- Back-to-back same requester: a request re-held through RESP is accepted in IDLE at t+3.
- Bus outputs are driven from registers, with no combinational path from request inputs. `stall` is the only combinational output.

## Structure
- Package `mem_bus_pkg` contains:
  - the state enum `arb_state_t` {IDLE, FETCH, DATA, RESP}
  - the grant enum `grant_t` {GNT_FETCH, GNT_DATA}
  - constant `BE_WORD` = 4'b1111
- Sub-module `rr_arb2`: two-requester round-robin grant from {req_fetch, req_data, last_grant}. It is combinational, with `last_grant` held in the parent.

## Test plan
- Single fetch: `ifetch_req`=1, `ifetch_addr`=0xBFC00000, `waitrequest`=0, `readdata`=0x24020005 → `bus_read` at t+1 with address 0xBFC00000; `ifetch_valid`=1 with rdata 0x24020005 at t+2; `stall` low at t+2.
- Wait states: store to 0x00001004 with wdata 0xDEADBEEF, BE=0011, `waitrequest` high for 3 cycles → `bus_write`, address, data and BE stable for 4 cycles; `dmem_done` at t+5; no `ifetch_valid`.
- Tie after reset: both requests high at cycle 1 → fetch granted first, data granted at t+3; then both high again → fetch granted next (alternation).
- Unaligned fetch: `ifetch_addr`=0x00000006 → `bus_address`=0x00000004.
- Reset mid-access: `reset` asserted during DATA with `waitrequest`=1 → next cycle strobes=0, no done pulse, rdata=0.
- Input change during transaction: `dmem_addr` changed while waiting → `bus_address` unchanged until completion.
